mem8x8_arbiter: RTL
===================

// Module: mem8x8_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer for the shared 8x8 memory and its tri-state data bus.
//  Latches one request (op/addr/wdata) and drives the memory-side sel/op/addr lines.
//  Owns the tri-state enable on mem_data, waits for the memory FSM's valid, and returns read data plus done/err.
//  Sits between the processing elements and the mem8x8 + control FSM.
// PARAMETERS
//  ADDR_W   3  memory address width (8 words)
//  DATA_W   8  memory word width
//  TIMEOUT  8  max WAIT cycles before abort with err (>=1); counter width $clog2(TIMEOUT+1)
// PORTS
//  clkPE      in    1       clock, rising edge
//  rst_n      in    1       asynchronous reset, active low
//  req0/req1  in    1       request from requester 0/1; hold high until done
//  op0/op1    in    1       1=write, 0=read; sampled with req in IDLE
//  addr0/1    in    ADDR_W  address; sampled with req in IDLE
//  wdata0/1   in    DATA_W  write data; sampled with req in IDLE
//  gnt0/gnt1  out   1       grant; high from ISSUE through DONE for winner
//  done0/1    out   1       1-cycle pulse in DONE for winner
//  err        out   1       high with done when transaction timed out
//  rdata      out   DATA_W  read data; valid with done on a read, held until next read
//  mem_sel    out   1       memory select, high in ISSUE and WAIT
//  mem_op     out   1       latched op to memory FSM, held ISSUE..WAIT
//  mem_addr   out   ADDR_W  latched address, held ISSUE..WAIT
//  mem_data   inout DATA_W  shared tri-state bus; driven only when mem_oe
//  mem_oe     out   1       high in ISSUE/WAIT on writes only; bus is 'z' otherwise
//  mem_valid  in    1       memory FSM completion strobe
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, all outputs 0, rdata=0, mem_data='z'.
//    - last=1, so requester 0 wins the first tie.
//    - Reset mid-transaction aborts immediately: mem_sel/mem_oe drop with rst_n, no done.
//  - FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//  - IDLE: if req0|req1, pick the winner, latch op/addr/wdata, then go to ISSUE; else stay.
//    - Only one req: that requester wins.
//    - Both req: requester != last wins (round robin).
//  - ISSUE: 1 cycle; mem_sel=1, mem_op/mem_addr valid, mem_oe=op, gnt=1; go to WAIT, clear timer.
//  - WAIT: hold all memory outputs.
//    - mem_valid=1: on a read, capture mem_data into rdata; go to DONE, err=0.
//    - Else timer+1; timer==TIMEOUT-1 with no valid: go to DONE, err=1, rdata unchanged.
//    - mem_valid is ignored outside WAIT.
//  - DONE: 1 cycle; done=1 and gnt=1 for winner, mem_sel=0, mem_oe=0; last<=winner; go to IDLE.
//  - Latency: req sampled at edge N; mem_sel high N+1..; done earliest at cycle N+3 (valid in first WAIT cycle).
//  - Minimum 4 cycles per transaction; back-to-back service alternates under contention.
//  - Requests change only in IDLE: req dropping mid-transaction does not cancel it (done still pulses).
//    - Changes to op/addr/wdata after latch are ignored.
//  - req still high in the IDLE cycle after done counts as a new request.
//  - gnt0/gnt1 and done0/done1 are never high simultaneously.
// CONFIGURATION
//  MEM_ARB_FIXED_PRIO_EN defined: requester 0 always wins ties; last is not used for selection.
//  Not defined (default): round robin as above.
// TESTING
//  1. Reset, req0=1 op0=1 addr0=3 wdata0=8'hA5, valid in WAIT:
//     mem_sel 2 cycles, mem_oe=1, mem_data=A5, done0 at N+3, err=0.
//  2. Read addr0=3 after test 1, memory returns A5: rdata=8'hA5 with done0, mem_oe stays 0, bus 'z'.
//  3. req0 and req1 held high for 4 transactions:
//     grants 0,1,0,1; with MEM_ARB_FIXED_PRIO_EN grants 0,0,0,0.
//  4. mem_valid never asserted, TIMEOUT=8: done with err=1 after 8 WAIT cycles, rdata unchanged.
//  5. Deassert rst_n during WAIT: mem_sel/mem_oe/gnt drop asynchronously, no done.
//     Next req is serviced normally from IDLE.
//  6. Drop req1 during WAIT and change addr1: transaction completes on the latched addr, done1 still pulses.

Source files
------------

// File: rtl/mem8x8_arbiter.sv
// mem8x8_arbiter: two-requester arbiter/sequencer for the shared 8x8 memory and its tri-state data bus
//   clkPE, rst_n           clock (rising edge), asynchronous active-low reset
//   req*/op*/addr*/wdata*  requester side: request, 1=write, address, write data
//   gnt*/done*/err/rdata   grant, 1-cycle completion pulse, timeout flag, read data
//   mem_sel/op/addr/oe     memory FSM side: select, operation, address, bus drive enable
//   mem_data (inout)       shared tri-state data bus, driven only while mem_oe
//   mem_valid              memory FSM completion strobe
//   MEM_ARB_FIXED_PRIO_EN  define for fixed priority (requester 0 wins ties); default round robin
module mem8x8_arbiter #(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 8
) (
  input  logic              clkPE,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              op0,
  input  logic              op1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_sel,
  output logic              mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              mem_oe,
  input  logic              mem_valid
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t            state, state_nx;
  logic              win, pick, op_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [TW-1:0]     timer;
`ifdef MEM_ARB_FIXED_PRIO_EN
  // requester 1 only wins when requester 0 is idle
  assign pick = !req0;
`else
  logic last;
  // on a tie the requester that was not served last wins
  assign pick = (req0 && req1) ? !last : req1;
  always_ff @(posedge clkPE or negedge rst_n)
    if (!rst_n) last <= 1'b1;
    else if (state == DONE) last <= win;
`endif
  always_ff @(posedge clkPE or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (req0 || req1) ? ISSUE : IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = (mem_valid || timer == TW'(TIMEOUT - 1)) ? DONE : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clkPE or negedge rst_n)
    if (!rst_n) begin
      win     <= 1'b0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      timer   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && (req0 || req1)) begin
        win     <= pick;
        op_q    <= pick ? op1 : op0;
        addr_q  <= pick ? addr1 : addr0;
        wdata_q <= pick ? wdata1 : wdata0;
      end
      if (state == ISSUE) timer <= '0;
      if (state == WAIT) begin
        timer <= timer + TW'(1);
        // the value left on the WAIT->DONE edge is the transaction's outcome
        err_q <= !mem_valid;
        if (mem_valid && !op_q) rdata_q <= mem_data;
      end
    end
  always_comb begin
    mem_sel  = (state == ISSUE) || (state == WAIT);
    mem_op   = mem_sel ? op_q : 1'b0;
    mem_addr = mem_sel ? addr_q : '0;
    mem_oe   = mem_sel && op_q;
    gnt0     = (state != IDLE) && !win;
    gnt1     = (state != IDLE) && win;
    done0    = (state == DONE) && !win;
    done1    = (state == DONE) && win;
    err      = (state == DONE) && err_q;
    rdata    = rdata_q;
  end
  assign mem_data = mem_oe ? wdata_q : 'z;
endmodule
